// File: rtl/cpu_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Holds the arbiter state encoding and the latency-counter width.
package cpu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    localparam int MEM_LATENCY_DEF = 2;
    localparam int STARVE_MAX_DEF  = 4;
    // Wide enough for MEM_LATENCY up to 7.
    localparam int LAT_CNT_W       = 3;

endpackage

// File: rtl/mem_arbiter_v_if.sv
// Bundle of fetch, data and memory-macro signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline/memory.
interface mem_arbiter_v_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              flush;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/arb_lat_ctr_v.sv
// Latency counter for one memory access: started on the grant cycle,
// it pulses done on the MEM_LATENCY-th cycle after the start.
module arb_lat_ctr_v
    import cpu_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);
    localparam logic [LAT_CNT_W-1:0] LAST = LAT_CNT_W'(MEM_LATENCY - 1);

    logic                 active_reg;
    logic [LAT_CNT_W-1:0] lat_cnt_reg;

    assign done = active_reg && (lat_cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            active_reg  <= 1'b0;
            lat_cnt_reg <= '0;
        end else if (start) begin
            active_reg  <= 1'b1;
            lat_cnt_reg <= '0;
        end else if (active_reg) begin
            if (done) begin
                active_reg  <= 1'b0;
                lat_cnt_reg <= '0;
            end else begin
                lat_cnt_reg <= lat_cnt_reg + LAT_CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/mem_arbiter_v.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// data first with a streak limit so fetch cannot starve; one access in flight.
module mem_arbiter_v
    import cpu_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int STARVE_MAX  = STARVE_MAX_DEF,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_v_if.slave bus
);
    localparam int                  STREAK_W   = $clog2(STARVE_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(STARVE_MAX);

    arb_state_t          state_reg, state_next;
    logic                drop_reg;
    logic                store_reg;
    logic [STREAK_W-1:0] streak_reg;
    logic                if_gnt_c, d_gnt_c, lat_done;
    logic                if_rvalid_c, d_rvalid_c;
    logic [ADDR_W-1:0]   addr_mux;
    logic [DATA_W-1:0]   wdata_mux;

    arb_lat_ctr_v #(.MEM_LATENCY(MEM_LATENCY)) u_lat_ctr (
        .clk   (clk),
        .reset (reset),
        .start (if_gnt_c || d_gnt_c),
        .done  (lat_done)
    );

    always_ff @(posedge clk) begin
        if (reset) state_reg <= ARB_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if_gnt_c   = 1'b0;
        d_gnt_c    = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                // Grants are combinational from the requests; reset masks them.
                if (!reset) begin
                    if (bus.d_req && (!bus.if_req || streak_reg < STREAK_SAT)) begin
                        d_gnt_c    = 1'b1;
                        state_next = ARB_BUSY_D;
                    end else if (bus.if_req && !bus.flush) begin
                        if_gnt_c   = 1'b1;
                        state_next = ARB_BUSY_I;
                    end
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (lat_done) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_reg   <= 1'b0;
            store_reg  <= 1'b0;
            streak_reg <= '0;
        end else begin
            if (d_gnt_c) store_reg <= bus.d_we;

            if (lat_done)                                    drop_reg <= 1'b0;
            else if (state_reg == ARB_BUSY_I && bus.flush)   drop_reg <= 1'b1;

            if (if_gnt_c) begin
                streak_reg <= '0;
            end else if (d_gnt_c) begin
                if (!bus.if_req)                  streak_reg <= '0;
                else if (streak_reg != STREAK_SAT) streak_reg <= streak_reg + STREAK_W'(1);
            end
        end
    end

    // A flush landing on the completion cycle also cancels the fetch.
    assign if_rvalid_c = !reset && (state_reg == ARB_BUSY_I) && lat_done
                         && !drop_reg && !bus.flush;
    assign d_rvalid_c  = !reset && (state_reg == ARB_BUSY_D) && lat_done;

    assign addr_mux  = d_gnt_c ? bus.d_addr  : (if_gnt_c ? bus.if_addr : '0);
    assign wdata_mux = d_gnt_c ? bus.d_wdata : '0;

    assign bus.if_gnt    = if_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.mem_en    = if_gnt_c || d_gnt_c;
    assign bus.mem_we    = d_gnt_c && bus.d_we;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.if_rvalid = if_rvalid_c;
    assign bus.d_rvalid  = d_rvalid_c;
    assign bus.if_rdata  = if_rvalid_c ? bus.mem_rdata : '0;
    assign bus.d_rdata   = (d_rvalid_c && !store_reg) ? bus.mem_rdata : '0;
    assign bus.busy      = !reset && (state_reg != ARB_IDLE);
endmodule

// File: tb/tb_mem_arbiter_v.sv
// Bench for mem_arbiter_v: directed scenarios plus random traffic, all checked
// every cycle against a schedule-based model of grants, completions and memory.
module tb_mem_arbiter_v;
    localparam int L    = 2;
    localparam int SMAX = 2;

    logic clk = 1'b0;
    logic reset;

    mem_arbiter_v_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter_v #(
        .MEM_LATENCY(L), .STARVE_MAX(SMAX), .ADDR_W(32), .DATA_W(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Memory macro and model state
    logic [31:0] mem_arr [256];
    int          owner    = 0;   // 0 none, 1 fetch, 2 data
    int          done_cyc = -1;
    int          rd_cyc   = -1;
    int          streak   = 0;
    bit          drop     = 1'b0;
    bit          store    = 1'b0;
    logic [7:0]  rd_addr  = 8'h0;
    logic [31:0] t_addr   = 32'h0;

    logic        e_if_gnt, e_d_gnt, e_if_rvalid, e_d_rvalid, e_mem_en, e_mem_we, e_busy;
    logic [31:0] e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata;
    logic        s_if_gnt, s_d_gnt, s_if_rvalid, s_d_rvalid, s_mem_en, s_mem_we, s_busy;
    logic [31:0] s_if_rdata, s_d_rdata, s_mem_wdata, s_mem_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive memory data, evaluate the model, compare, advance.
    task automatic step();
        logic [31:0] rd;
        rd = (rd_cyc == cyc) ? mem_arr[rd_addr] : $urandom;
        bus.mem_rdata = rd;
        #3;
        {e_if_gnt, e_d_gnt, e_if_rvalid, e_d_rvalid, e_mem_en, e_mem_we, e_busy} = '0;
        {e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata} = '0;
        if (reset) begin
            owner = 0; drop = 1'b0; streak = 0;
        end else if (owner == 0) begin
            if (bus.d_req && (!bus.if_req || streak < SMAX)) begin
                e_d_gnt = 1'b1; e_mem_en = 1'b1; e_mem_we = bus.d_we;
                e_mem_addr = bus.d_addr; e_mem_wdata = bus.d_wdata;
                if (bus.d_we) mem_arr[bus.d_addr[7:0]] = bus.d_wdata;
                owner = 2; store = bus.d_we; t_addr = bus.d_addr;
                done_cyc = cyc + L; rd_cyc = cyc + L; rd_addr = bus.d_addr[7:0];
                streak = bus.if_req ? ((streak + 1 > SMAX) ? SMAX : streak + 1) : 0;
            end else if (bus.if_req && !bus.flush) begin
                e_if_gnt = 1'b1; e_mem_en = 1'b1; e_mem_addr = bus.if_addr;
                owner = 1; t_addr = bus.if_addr;
                done_cyc = cyc + L; rd_cyc = cyc + L; rd_addr = bus.if_addr[7:0];
                streak = 0;
            end
        end else begin
            e_busy = 1'b1;
            if (cyc == done_cyc) begin
                if (owner == 1) begin
                    if (!drop && !bus.flush) begin
                        e_if_rvalid = 1'b1; e_if_rdata = rd;
                        $display("cyc %0d fetch addr=%h data=%h", cyc, t_addr, rd);
                    end else begin
                        $display("cyc %0d fetch addr=%h dropped by flush", cyc, t_addr);
                    end
                end else begin
                    e_d_rvalid = 1'b1; e_d_rdata = store ? 32'h0 : rd;
                    $display("cyc %0d %s addr=%h data=%h", cyc, store ? "store" : "load",
                             t_addr, e_d_rdata);
                end
                owner = 0; drop = 1'b0;
            end else if (owner == 1 && bus.flush) begin
                drop = 1'b1;
            end
        end
        s_if_gnt = bus.if_gnt; s_d_gnt = bus.d_gnt; s_if_rvalid = bus.if_rvalid;
        s_d_rvalid = bus.d_rvalid; s_mem_en = bus.mem_en; s_mem_we = bus.mem_we;
        s_busy = bus.busy; s_if_rdata = bus.if_rdata; s_d_rdata = bus.d_rdata;
        s_mem_wdata = bus.mem_wdata; s_mem_addr = bus.mem_addr;
        chk("if_gnt", 32'(s_if_gnt), 32'(e_if_gnt));
        chk("d_gnt", 32'(s_d_gnt), 32'(e_d_gnt));
        chk("if_rvalid", 32'(s_if_rvalid), 32'(e_if_rvalid));
        chk("d_rvalid", 32'(s_d_rvalid), 32'(e_d_rvalid));
        chk("mem_en", 32'(s_mem_en), 32'(e_mem_en));
        chk("mem_we", 32'(s_mem_we), 32'(e_mem_we));
        chk("busy", 32'(s_busy), 32'(e_busy));
        chk("mem_addr", s_mem_addr, e_mem_addr);
        chk("mem_wdata", s_mem_wdata, e_mem_wdata);
        if (e_if_rvalid || reset) chk("if_rdata", s_if_rdata, e_if_rdata);
        if (e_d_rvalid || reset)  chk("d_rdata", s_d_rdata, e_d_rdata);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.flush = 1'b0; reset = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        string seq;
        bit    if_pend, d_pend;
        for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
        mem_arr[8'h10] = 32'h00500093;
        reset = 1'b1; bus.flush = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0;
        @(posedge clk);
        #1;

        // Reset state
        step();
        bus.d_req = 1'b1; bus.if_req = 1'b1;
        step();
        chk("rst_busy", 32'(s_busy), 32'h0);
        chk("rst_mem_en", 32'(s_mem_en), 32'h0);
        chk("rst_mem_addr", s_mem_addr, 32'h0);
        idle(2);

        // Lone fetch, then back-to-back request waits for the issue slot
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        step();
        chk("t1_if_gnt", 32'(s_if_gnt), 32'h1);
        chk("t1_mem_addr", s_mem_addr, 32'h10);
        bus.if_addr = 32'h14;
        step();
        chk("t1_no_gnt_t1", 32'(s_if_gnt), 32'h0);
        step();
        chk("t1_if_rvalid", 32'(s_if_rvalid), 32'h1);
        chk("t1_if_rdata", s_if_rdata, 32'h00500093);
        chk("t1_no_gnt_t2", 32'(s_if_gnt), 32'h0);
        step();
        chk("t1_gnt_t3", 32'(s_if_gnt), 32'h1);
        idle(3);

        // Contention: data wins, fetch follows after completion
        bus.if_req = 1'b1; bus.if_addr = 32'h14;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.d_wdata = 32'h0;
        step();
        chk("t2_d_gnt", 32'(s_d_gnt), 32'h1);
        chk("t2_if_gnt", 32'(s_if_gnt), 32'h0);
        bus.d_req = 1'b0;
        step();
        step();
        chk("t2_d_rvalid", 32'(s_d_rvalid), 32'h1);
        step();
        chk("t2_if_gnt_t3", 32'(s_if_gnt), 32'h1);
        idle(3);

        // Starvation limit
        seq = "";
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        for (int i = 0; i < 21; i++) begin
            step();
            if (s_d_gnt)       seq = {seq, "D"};
            else if (s_if_gnt) seq = {seq, "I"};
        end
        n_cmp++;
        if (seq != "DDIDDID") begin
            n_bad++;
            $display("FAIL t3_grant_seq actual=%s required=DDIDDID", seq);
        end
        idle(3);

        // Store
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'hDEADBEEF;
        step();
        chk("t4_mem_we", 32'(s_mem_we), 32'h1);
        chk("t4_mem_wdata", s_mem_wdata, 32'hDEADBEEF);
        bus.d_req = 1'b0;
        step();
        step();
        chk("t4_d_rvalid", 32'(s_d_rvalid), 32'h1);
        chk("t4_d_rdata", s_d_rdata, 32'h0);
        idle(2);

        // Flush of a fetch in flight
        bus.if_req = 1'b1; bus.if_addr = 32'h18;
        step();
        chk("t5_if_gnt", 32'(s_if_gnt), 32'h1);
        bus.if_req = 1'b0; bus.flush = 1'b1;
        step();
        bus.flush = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h1c;
        step();
        chk("t5_no_rvalid", 32'(s_if_rvalid), 32'h0);
        step();
        chk("t5_busy_t3", 32'(s_busy), 32'h0);
        chk("t5_if_gnt_t3", 32'(s_if_gnt), 32'h1);
        idle(3);

        // Reset in the middle of a load
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        step();
        chk("t6_d_gnt", 32'(s_d_gnt), 32'h1);
        bus.d_req = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("t6_busy", 32'(s_busy), 32'h0);
        chk("t6_no_rvalid", 32'(s_d_rvalid), 32'h0);
        chk("t6_mem_en", 32'(s_mem_en), 32'h0);
        bus.d_req = 1'b1; bus.d_addr = 32'h104;
        step();
        chk("t6_d_gnt_t3", 32'(s_d_gnt), 32'h1);
        idle(3);

        // Random traffic with request holding, flushes and occasional reset
        if_pend = 1'b0; d_pend = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if (!if_pend && $urandom_range(2) != 0) begin
                if_pend = 1'b1;
                bus.if_addr = {24'h0, 6'($urandom), 2'b00};
            end
            if (!d_pend && $urandom_range(2) != 0) begin
                d_pend = 1'b1;
                bus.d_we = 1'($urandom_range(1));
                bus.d_addr = {24'h0, 6'($urandom), 2'b00};
                bus.d_wdata = $urandom;
            end
            bus.if_req = if_pend;
            bus.d_req  = d_pend;
            bus.flush  = ($urandom_range(7) == 0);
            reset      = ($urandom_range(199) == 0);
            step();
            if (e_if_gnt) if_pend = 1'b0;
            if (e_d_gnt)  d_pend = 1'b0;
            if (bus.flush && if_pend) bus.if_addr = {24'h0, 6'($urandom), 2'b00};
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
